// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolution sequencer: stalls F/D until operands are final, then
// emits a registered resolve pulse with the taken decision and next-fetch PC.
// Optional build macro BR_STATS_EN adds taken/not-taken/stall event counters.
module branch_resolve_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int WCNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [2:0]  br_type,
    input  logic        rs_ready,
    input  logic        rt_ready,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    input  logic        flush,
    output logic        stall,
    output logic        br_ack,
    output logic        resolve_valid,
    output logic        br_taken,
    output logic [31:0] redirect_pc,
    output logic        err_timeout,
`ifdef BR_STATS_EN
    output logic [15:0] cnt_taken,
    output logic [15:0] cnt_not_taken,
    output logic [15:0] cnt_stall,
`endif
    output logic [0:0]  dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [WCNT_W-1:0] CNT_SAT   = '1;
    localparam logic [WCNT_W-1:0] CNT_ONE   = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] CNT_LIMIT = WCNT_W'(MAX_WAIT);

    // Handshake: br_valid is held by D until br_ack (or a flush drops it);
    // br_ack is the single accept point and triggers the resolve pulse on the next edge.
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [WCNT_W-1:0] r_cnt;
    logic [WCNT_W-1:0] w_cnt_nxt;
    logic              r_resolve_valid;
    logic              r_br_taken;
    logic [31:0]       r_redirect_pc;
    logic              r_err_timeout;

    logic        w_need_rt;
    logic        w_ready;
    logic        w_ack;
    logic        w_eq;
    logic        w_rs_lt_rt;
    logic        w_rt_lt_rs;
    logic        w_rs_zero;
    logic        w_cond;
    logic [31:0] w_target;

    assign w_need_rt = (br_type == 3'd0) || (br_type == 3'd1) ||
                       (br_type == 3'd6) || (br_type == 3'd7);
    assign w_ready   = rs_ready && (rt_ready || !w_need_rt);
    // Reset masks the combinational handshake so every output reads 0 while it is held.
    assign w_ack     = br_valid && w_ready && !flush && !reset;
    assign stall     = br_valid && !w_ready && !flush && !reset;
    assign br_ack    = w_ack;

    assign w_eq       = (rs_val == rt_val);
    assign w_rs_zero  = (rs_val == 32'd0);
    assign w_rs_lt_rt = (rs_val[31] && !rt_val[31]) ||
                        ((rs_val[31] == rt_val[31]) && (rs_val < rt_val));
    assign w_rt_lt_rs = (rt_val[31] && !rs_val[31]) ||
                        ((rs_val[31] == rt_val[31]) && (rt_val < rs_val));

    always_comb begin
        w_cond = 1'b0;
        case (br_type)
            3'd0:    w_cond = w_eq;
            3'd1:    w_cond = !w_eq;
            3'd2:    w_cond = !rs_val[31] && !w_rs_zero;
            3'd3:    w_cond = rs_val[31] || w_rs_zero;
            3'd4:    w_cond = rs_val[31];
            3'd5:    w_cond = !rs_val[31];
            3'd6:    w_cond = w_rt_lt_rs;
            3'd7:    w_cond = w_rs_lt_rt;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (br_valid && !w_ready && !flush) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_WAIT: begin
                // Leaving WAIT covers ack, flush and D withdrawing the branch.
                if (flush || !br_valid || w_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_resolve_valid <= 1'b0;
            r_br_taken      <= 1'b0;
            r_redirect_pc   <= 32'd0;
            r_err_timeout   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_resolve_valid <= w_ack;
            if (w_ack) begin
                r_br_taken    <= w_cond;
                r_redirect_pc <= w_cond ? w_target : (pc_plus4 + 32'd4);
            end
            if (w_cnt_nxt >= CNT_LIMIT) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign resolve_valid = r_resolve_valid;
    assign br_taken      = r_br_taken;
    assign redirect_pc   = r_redirect_pc;
    assign err_timeout   = r_err_timeout;
    assign dbg_state     = r_state;

`ifdef BR_STATS_EN
    logic [15:0] r_cnt_taken;
    logic [15:0] r_cnt_not_taken;
    logic [15:0] r_cnt_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_taken     <= 16'd0;
            r_cnt_not_taken <= 16'd0;
            r_cnt_stall     <= 16'd0;
        end else begin
            if (r_resolve_valid && r_br_taken) begin
                r_cnt_taken <= r_cnt_taken + 16'd1;
            end
            if (r_resolve_valid && !r_br_taken) begin
                r_cnt_not_taken <= r_cnt_not_taken + 16'd1;
            end
            if (stall) begin
                r_cnt_stall <= r_cnt_stall + 16'd1;
            end
        end
    end

    assign cnt_taken     = r_cnt_taken;
    assign cnt_not_taken = r_cnt_not_taken;
    assign cnt_stall     = r_cnt_stall;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl; expected values are hand-computed.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        reset;
    logic        br_valid;
    logic [2:0]  br_type;
    logic        rs_ready;
    logic        rt_ready;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;
    logic        flush;
    logic        stall;
    logic        br_ack;
    logic        resolve_valid;
    logic        br_taken;
    logic [31:0] redirect_pc;
    logic        err_timeout;
    logic [0:0]  dbg_state;
`ifdef BR_STATS_EN
    logic [15:0] cnt_taken;
    logic [15:0] cnt_not_taken;
    logic [15:0] cnt_stall;
    logic [15:0] taken_before;
`endif

    int checks;
    int failures;

    branch_resolve_ctrl #(.MAX_WAIT(15), .WCNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .br_valid      (br_valid),
        .br_type       (br_type),
        .rs_ready      (rs_ready),
        .rt_ready      (rt_ready),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .pc_plus4      (pc_plus4),
        .imm16         (imm16),
        .flush         (flush),
        .stall         (stall),
        .br_ack        (br_ack),
        .resolve_valid (resolve_valid),
        .br_taken      (br_taken),
        .redirect_pc   (redirect_pc),
        .err_timeout   (err_timeout),
`ifdef BR_STATS_EN
        .cnt_taken     (cnt_taken),
        .cnt_not_taken (cnt_not_taken),
        .cnt_stall     (cnt_stall),
`endif
        .dbg_state     (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt,
                              input logic rsr, input logic rtr,
                              input logic [31:0] pc4, input logic [15:0] imm);
        br_valid = 1'b1;
        br_type  = t;
        rs_val   = rs;
        rt_val   = rt;
        rs_ready = rsr;
        rt_ready = rtr;
        pc_plus4 = pc4;
        imm16    = imm;
    endtask

    // Single-operand vectors: type, rs, expected taken (rt never ready).
    logic [2:0]  v_type [4] = '{3'd4, 3'd5, 3'd3, 3'd2};
    logic [31:0] v_rs   [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0};
    logic        v_tk   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        br_valid = 1'b0;
        br_type  = 3'd0;
        rs_ready = 1'b0;
        rt_ready = 1'b0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        pc_plus4 = 32'd0;
        imm16    = 16'd0;
        flush    = 1'b0;

        #1;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_ack", {31'd0, br_ack}, 32'd0);
        check_eq("rst_resolve", {31'd0, resolve_valid}, 32'd0);
        check_eq("rst_taken", {31'd0, br_taken}, 32'd0);
        check_eq("rst_redirect", redirect_pc, 32'd0);
        check_eq("rst_err", {31'd0, err_timeout}, 32'd0);
        check_eq("rst_state", {31'd0, dbg_state}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // beq taken, ack in same cycle
        set_branch(3'd0, 32'h5, 32'h5, 1'b1, 1'b1, 32'h3004, 16'h0003);
        #1;
        check_eq("beq_ack", {31'd0, br_ack}, 32'd1);
        check_eq("beq_stall", {31'd0, stall}, 32'd0);
        tick();
        br_valid = 1'b0;
        check_eq("beq_resolve", {31'd0, resolve_valid}, 32'd1);
        check_eq("beq_taken", {31'd0, br_taken}, 32'd1);
        check_eq("beq_redirect", redirect_pc, 32'h3010);
        tick();
        check_eq("beq_pulse_end", {31'd0, resolve_valid}, 32'd0);

        // blt then bgt back-to-back, signed operands
        set_branch(3'd7, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h1000, 16'h0010);
        #1;
        check_eq("blt_ack", {31'd0, br_ack}, 32'd1);
        tick();
        br_type = 3'd6;
        check_eq("blt_resolve", {31'd0, resolve_valid}, 32'd1);
        check_eq("blt_taken", {31'd0, br_taken}, 32'd1);
        check_eq("blt_redirect", redirect_pc, 32'h1040);
        #1;
        check_eq("bgt_ack", {31'd0, br_ack}, 32'd1);
        tick();
        br_valid = 1'b0;
        check_eq("bgt_resolve", {31'd0, resolve_valid}, 32'd1);
        check_eq("bgt_taken", {31'd0, br_taken}, 32'd0);
        check_eq("bgt_redirect", redirect_pc, 32'h1004);
        tick();
        check_eq("bgt_pulse_end", {31'd0, resolve_valid}, 32'd0);

        // bgtz with rs late for 3 cycles, rt never ready
        set_branch(3'd2, 32'h7, 32'h0, 1'b0, 1'b0, 32'h2000, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bgtz_stall", {31'd0, stall}, 32'd1);
            check_eq("bgtz_noack", {31'd0, br_ack}, 32'd0);
            tick();
            check_eq("bgtz_nopulse", {31'd0, resolve_valid}, 32'd0);
            check_eq("bgtz_state_wait", {31'd0, dbg_state}, 32'd1);
        end
        rs_ready = 1'b1;
        #1;
        check_eq("bgtz_ack", {31'd0, br_ack}, 32'd1);
        check_eq("bgtz_stall_off", {31'd0, stall}, 32'd0);
        tick();
        br_valid = 1'b0;
        check_eq("bgtz_resolve", {31'd0, resolve_valid}, 32'd1);
        check_eq("bgtz_taken", {31'd0, br_taken}, 32'd1);
        check_eq("bgtz_redirect", redirect_pc, 32'h1FFC);
        check_eq("bgtz_state_idle", {31'd0, dbg_state}, 32'd0);
        tick();
        check_eq("bgtz_single_pulse", {31'd0, resolve_valid}, 32'd0);

        // bne waiting 16 cycles: timeout at count 15, sticky
        set_branch(3'd1, 32'h1, 32'h2, 1'b0, 1'b1, 32'h4000, 16'h0008);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 14) check_eq("tmo_not_yet", {31'd0, err_timeout}, 32'd0);
            if (i == 15) check_eq("tmo_set", {31'd0, err_timeout}, 32'd1);
        end
        rs_ready = 1'b1;
        #1;
        check_eq("bne_ack", {31'd0, br_ack}, 32'd1);
        tick();
        br_valid = 1'b0;
        check_eq("bne_taken", {31'd0, br_taken}, 32'd1);
        check_eq("bne_redirect", redirect_pc, 32'h4020);
        tick();
        check_eq("tmo_sticky", {31'd0, err_timeout}, 32'd1);

        // flush while in WAIT, then flush against a would-be ack in IDLE
        set_branch(3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'h600, 16'h0001);
        tick();
        check_eq("fl_state_wait", {31'd0, dbg_state}, 32'd1);
        flush    = 1'b1;
        rs_ready = 1'b1;
        #1;
        check_eq("fl_noack", {31'd0, br_ack}, 32'd0);
        check_eq("fl_nostall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("fl_nopulse", {31'd0, resolve_valid}, 32'd0);
        check_eq("fl_state_idle", {31'd0, dbg_state}, 32'd0);
        #1;
        check_eq("fl_idle_noack", {31'd0, br_ack}, 32'd0);
        tick();
        flush    = 1'b0;
        br_valid = 1'b0;
        check_eq("fl_idle_nopulse", {31'd0, resolve_valid}, 32'd0);

        // single-operand conditions, rt never ready
        for (int i = 0; i < 4; i++) begin
            set_branch(v_type[i], v_rs[i], 32'h0, 1'b1, 1'b0, 32'h500, 16'h0004);
            #1;
            check_eq("one_op_ack", {31'd0, br_ack}, 32'd1);
            tick();
            br_valid = 1'b0;
            check_eq("one_op_taken", {31'd0, br_taken}, {31'd0, v_tk[i]});
            check_eq("one_op_redirect", redirect_pc, v_tk[i] ? 32'h510 : 32'h504);
            tick();
        end

        // target wraps past 2^32
`ifdef BR_STATS_EN
        taken_before = cnt_taken;
`endif
        set_branch(3'd0, 32'h9, 32'h9, 1'b1, 1'b1, 32'hFFFF_FFFC, 16'h0002);
        #1;
        check_eq("wrap_ack", {31'd0, br_ack}, 32'd1);
        tick();
        br_valid = 1'b0;
        check_eq("wrap_taken", {31'd0, br_taken}, 32'd1);
        check_eq("wrap_redirect", redirect_pc, 32'h0000_0004);
        tick();
`ifdef BR_STATS_EN
        check_eq("stats_taken", {16'd0, cnt_taken}, {16'd0, taken_before + 16'd1});
`endif

        // async reset in the middle of WAIT
        set_branch(3'd3, 32'h5, 32'h0, 1'b0, 1'b0, 32'h700, 16'h0001);
        tick();
        check_eq("ar_state_wait", {31'd0, dbg_state}, 32'd1);
        #3 reset = 1'b1;
        #1;
        check_eq("ar_state", {31'd0, dbg_state}, 32'd0);
        check_eq("ar_stall", {31'd0, stall}, 32'd0);
        check_eq("ar_ack", {31'd0, br_ack}, 32'd0);
        check_eq("ar_err", {31'd0, err_timeout}, 32'd0);
        check_eq("ar_taken", {31'd0, br_taken}, 32'd0);
        check_eq("ar_redirect", redirect_pc, 32'd0);
        check_eq("ar_resolve", {31'd0, resolve_valid}, 32'd0);
        br_valid = 1'b0;
        #2 reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
